mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Upstream driver and checker for the 8:1 mux (built from 4:1 muxes).
//  - Latches an 8-bit word onto the mux data inputs i0..i7.
//  - Steps the select lines s2:s0 through all 8 codes, samples mux output y for each, and streams it out serially.
//  - Reassembles the samples into rx_data and flags match when rx_data equals the latched word.
//  - Serves as the mux's parallel-to-serial front end and as its built-in self-check.
// PARAMETERS
//  HOLD_CYC   1   cycles each select code is held before y is sampled (legal range 1..15)
//  MSB_FIRST  0   0: select order 0->7; 1: select order 7->0
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous reset, active low
//  start      in   1  request a scan; accepted only in IDLE
//  abort      in   1  synchronous abort of an active scan
//  data_in    in   8  word to scan; latched when start is accepted
//  y          in   1  mux output (combinational return path from the mux)
//  i0..i7     out  1  each; mux data inputs, registered; i[k] = latched data_in[k]
//  s0,s1,s2   out  1  each; mux select, registered; {s2,s1,s0} = current bit index
//  busy       out  1  high in SCAN and DONE
//  ser_out    out  1  sampled y
//  ser_valid  out  1  ser_out is valid this cycle
//  rx_data    out  8  reassembled word; bit k = y sampled while sel == k
//  done       out  1  one-cycle pulse at the end of a completed scan
//  match      out  1  (rx_data == latched word); updated together with done, held until the next done
// BEHAVIOUR
//  Reset: state=IDLE; every output = 0; hold_cnt = 0; internal capture register = 0.
//  States: IDLE, SCAN, DONE.
//  IDLE
//   - start=1 -> latch data_in to i0..i7.
//   - Set sel to 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1); hold_cnt=0; go to SCAN.
//  SCAN, every edge:
//   - hold_cnt increments.
//   - Sample edge is the edge where hold_cnt == HOLD_CYC-1. At that edge:
//     - capture y into capture bit [sel];
//     - ser_out <= y and ser_valid <= 1 (ser_valid is high for exactly one cycle after each sample edge);
//     - hold_cnt <= 0.
//   - If sel is the last code -> go to DONE; otherwise sel steps by +1 or -1.
//   - Sel, and therefore s2:s0, is stable for exactly HOLD_CYC cycles per code, so y has settled by the sample edge.
//  DONE (one cycle)
//   - done=1; rx_data and match are updated from the capture register in this cycle.
//   - Next state is IDLE.
//  Latency: done rises 8*HOLD_CYC edges after the edge that accepted start. The last ser_valid coincides with done.
//  start while busy: ignored; the latched word is unchanged.
//  abort in SCAN or DONE:
//   - next state IDLE; no done pulse; rx_data and match keep their previous values;
//   - s2:s0 <= 0; ser_valid <= 0; i0..i7 keep their values.
//  abort in IDLE: no effect. abort and start together in IDLE: abort wins and the scan does not start.
//  Reset mid-scan: immediate (asynchronous) return to the reset values above.
//  sel never wraps: exactly 8 samples are taken per scan.
// STRUCTURE
//  - Shared include mux_scan_defs.vh: state localparams (IDLE=2'b00, SCAN=2'b01, DONE=2'b10), SEL_W=3, N_IN=8.
//  - One sub-module, mux_scan_timer: holds hold_cnt (4 bits) and emits a sample_tick strobe.
//    Cleared by rst_n, by abort, and on entry to SCAN.
//  - Top level: FSM, sel register, capture register, output registers.
// TESTING (the bench instantiates this block and the mux, with y wired back)
//  1. HOLD_CYC=1, MSB_FIRST=0, data_in=8'hC4, start pulse:
//     ser_out on successive ser_valid = 0,0,1,0,0,0,1,1; done 8 cycles after start; rx_data=8'hC4; match=1.
//  2. MSB_FIRST=1, data_in=8'hC4:
//     stream = 1,1,0,0,0,1,0,0; {s2,s1,s0} sequence 7..0; rx_data=8'hC4; match=1.
//  3. HOLD_CYC=3, data_in=8'h5A:
//     each select code held 3 cycles; ser_valid spaced 3 cycles apart; done 24 cycles after start; match=1.
//  4. Force y=0, data_in=8'hFF: rx_data=8'h00, match=0.
//     Then release y, data_in=8'h00: match=1 (stuck-at-0 is not detectable on an all-zero word).
//  5. Abort on the cycle of the 4th ser_valid: busy=0 next cycle; no done; s=0; rx_data keeps its old value.
//     A second start pulsed while busy is ignored.
//  6. Assert rst_n=0 mid-scan with sel=5: all outputs 0 immediately.
//     After release, a new start with 8'h81 completes normally with match=1.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and sizes for the mux scan sequencer and its hold timer.
package mux_scan_sequencer_pkg;
    localparam int SEL_W = 3;
    localparam int N_IN  = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel, input logic down);
        return down ? sel - 1'b1 : sel + 1'b1;
    endfunction
endpackage

// File: rtl/mux_scan_timer.sv
// Hold counter for one select code; sample_tick marks the edge on which y is sampled.
module mux_scan_timer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int HOLD_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sample_tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYC - 1);

    logic [CNT_W-1:0] hold_cnt;

    assign sample_tick = en && (hold_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (clr || sample_tick)
            hold_cnt <= '0;
        else if (en)
            hold_cnt <= hold_cnt + 1'b1;
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives an 8:1 mux with a latched word, walks the selects, and serialises and
// re-checks the returned samples.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int HOLD_CYC  = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] data_in,
    input  logic       y,
    output logic       i0, i1, i2, i3, i4, i5, i6, i7,
    output logic       s0, s1, s2,
    output logic       busy,
    output logic       ser_out,
    output logic       ser_valid,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       match
);
    localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(N_IN - 1) : '0;
    localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : SEL_W'(N_IN - 1);

    state_t            state;
    logic [N_IN-1:0]   word_q, cap_q, cap_nxt;
    logic [SEL_W-1:0]  sel_q;
    logic              accept, scan_abort, tick;

    assign accept     = (state == ST_IDLE) && start && !abort;
    assign scan_abort = (state != ST_IDLE) && abort;

    mux_scan_timer #(.HOLD_CYC(HOLD_CYC)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept || scan_abort),
        .en          (state == ST_SCAN),
        .sample_tick (tick)
    );

    // Includes the bit being sampled now, so rx_data/match land with the last ser_valid.
    always_comb begin
        cap_nxt        = cap_q;
        cap_nxt[sel_q] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_q    <= '0;
            cap_q     <= '0;
            sel_q     <= '0;
            busy      <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            rx_data   <= '0;
            done      <= 1'b0;
            match     <= 1'b0;
        end else begin
            ser_valid <= 1'b0;
            done      <= 1'b0;
            if (scan_abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                sel_q <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (accept) begin
                        word_q <= data_in;
                        cap_q  <= '0;
                        sel_q  <= SEL_FIRST;
                        busy   <= 1'b1;
                        state  <= ST_SCAN;
                    end
                    ST_SCAN: if (tick) begin
                        cap_q     <= cap_nxt;
                        ser_out   <= y;
                        ser_valid <= 1'b1;
                        if (sel_q == SEL_LAST) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            rx_data <= cap_nxt;
                            match   <= (cap_nxt == word_q);
                        end else begin
                            sel_q <= sel_step(sel_q, MSB_FIRST);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign {i7, i6, i5, i4, i3, i2, i1, i0} = word_q;
    assign {s2, s1, s0} = sel_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Three sequencer configurations (hold 1 LSB-first, hold 1 MSB-first, hold 3
// LSB-first), each looped back through a behavioural 8:1 mux.
module tb_mux_scan_sequencer;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       start = '0;
    logic             abort = 1'b0;
    logic [7:0]       data_in = '0;
    logic             force_y0 = 1'b0;
    logic [2:0]       busy, ser_out, ser_valid, done, match;
    logic [2:0][7:0]  rx_a, i_a;
    logic [2:0][2:0]  sel_a;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int HC = (g == 2) ? 3 : 1;
        localparam bit MF = (g == 1);
        logic [7:0] iv;
        logic [2:0] sv;
        logic       yv;
        assign yv = force_y0 ? 1'b0 : iv[sv];
        mux_scan_sequencer #(.HOLD_CYC(HC), .MSB_FIRST(MF)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort),
            .data_in(data_in), .y(yv),
            .i0(iv[0]), .i1(iv[1]), .i2(iv[2]), .i3(iv[3]),
            .i4(iv[4]), .i5(iv[5]), .i6(iv[6]), .i7(iv[7]),
            .s0(sv[0]), .s1(sv[1]), .s2(sv[2]),
            .busy(busy[g]), .ser_out(ser_out[g]), .ser_valid(ser_valid[g]),
            .rx_data(rx_a[g]), .done(done[g]), .match(match[g])
        );
        assign i_a[g]   = iv;
        assign sel_a[g] = sv;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hold_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    // Select code visited k-th in a scan.
    function automatic int code_of(input int g, input int k);
        return (g == 1) ? 7 - k : k;
    endfunction

    // Full scan with the model: code k is sampled at edge h*(k+1) after accept.
    // poke>0 pulses a conflicting start at that cycle, which must be ignored.
    task automatic run_scan(input int g, input logic [7:0] w, input int poke);
        int h = hold_of(g);
        int nval = 0;
        logic [7:0] exp_rx = force_y0 ? 8'h00 : w;
        @(negedge clk);
        data_in = w; start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        for (int c = 1; c <= 8 * h + 1; c++) begin
            @(posedge clk); #1;
            start[g] = 1'b0;
            data_in  = w;
            chk("busy", busy[g], c <= 8 * h);
            chk("done", done[g], c == 8 * h);
            chk("ser_valid", ser_valid[g], (c % h == 0) && c <= 8 * h);
            if (ser_valid[g]) begin
                chk("ser_out", ser_out[g], exp_rx[code_of(g, nval)]);
                nval++;
            end
            if (c < 8 * h) chk("sel", sel_a[g], code_of(g, c / h));
            if (c == poke) begin
                start[g] = 1'b1;
                data_in  = ~w;
            end
        end
        chk("nvalid", nval, 8);
        chk("rx_data", rx_a[g], exp_rx);
        chk("match", match[g], exp_rx == w);
        chk("latch", i_a[g], w);
    endtask

    initial begin
        int ndone;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sv", ser_valid, 0);
        chk("rst_so", ser_out, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_rx", rx_a, 0);
        chk("rst_i", i_a, 0);
        chk("rst_sel", sel_a, 0);
        #20;
        @(negedge clk) rst_n = 1'b1;

        run_scan(0, 8'hC4, 0);
        run_scan(1, 8'hC4, 0);
        run_scan(2, 8'h5A, 5);

        force_y0 = 1'b1;
        run_scan(0, 8'hFF, 0);
        force_y0 = 1'b0;
        run_scan(0, 8'h00, 0);
        run_scan(0, 8'hC4, 0);

        // abort on the 4th sample, with a start pulse while busy
        @(negedge clk);
        data_in = 8'h3E; start[0] = 1'b1;
        @(posedge clk); #1;
        data_in = 8'h99;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
        end
        chk("ab_valid4", ser_valid[0], 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_busy", busy[0], 0);
        chk("ab_sel", sel_a[0], 0);
        chk("ab_sv", ser_valid[0], 0);
        chk("ab_rx", rx_a[0], 8'hC4);
        chk("ab_i", i_a[0], 8'h3E);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done[0]) ndone++;
        end
        chk("ab_nodone", ndone, 0);
        chk("ab_match", match[0], 1);

        // abort and start together in idle
        @(negedge clk);
        abort = 1'b1; start[0] = 1'b1; data_in = 8'h12;
        @(posedge clk); #1;
        abort = 1'b0; start[0] = 1'b0;
        @(posedge clk); #1;
        chk("abst_busy", busy[0], 0);
        chk("abst_i", i_a[0], 8'h3E);

        // asynchronous reset mid-scan at sel=5
        @(negedge clk);
        data_in = 8'h3C; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        chk("mr_sel5", sel_a[0], 5);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy[0], 0);
        chk("mr_sel", sel_a[0], 0);
        chk("mr_i", i_a[0], 0);
        chk("mr_rx", rx_a[0], 0);
        chk("mr_sv", ser_valid[0], 0);
        chk("mr_so", ser_out[0], 0);
        @(negedge clk) rst_n = 1'b1;
        run_scan(0, 8'h81, 0);

        for (int n = 0; n < 24; n++) begin
            int g = $urandom_range(0, 2);
            force_y0 = ($urandom_range(0, 5) == 0);
            run_scan(g, 8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
        end
        force_y0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
